// File: rtl/cpu_ocimem_pkg.sv
// cpu_ocimem_pkg: shared FSM/command types and jdo field map for the OCI monitor memory.
// Optional feature macro used by the top: OCIMEM_ROM_PROTECT_EN.
package cpu_ocimem_pkg;

  typedef enum logic [2:0] {IDLE, J_RD, J_WR, A_RD, A_ACK} ocimem_state_e;

  // Decoded JTAG strobe, also the payload kind of the pending register.
  typedef enum logic [1:0] {JC_NONE, JC_LOAD, JC_READ, JC_WRITE} jtag_cmd_e;

  localparam int unsigned JDO_W          = 38;
  localparam int unsigned JDO_ADDR_LSB   = 17;
  localparam int unsigned JDO_RDREQ      = 34;
  localparam int unsigned JDO_WDATA_LSB  = 3;
  localparam int unsigned JDO_ERRCLR     = 35;
  localparam int unsigned ROM_PROTECT_TOP = 63;

  function automatic logic rom_protected(input int unsigned word_addr);
    return word_addr <= ROM_PROTECT_TOP;
  endfunction

endpackage

// File: rtl/cpu_ocimem_ram.sv
// cpu_ocimem_ram: single-port synchronous RAM with byte enables.
module cpu_ocimem_ram #(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned DATA_W    = 32,
  parameter string       INIT_FILE = ""
) (
  input  logic                  clk,
  input  logic [ADDR_W-1:0]     i_addr,
  input  logic                  i_we,
  input  logic [DATA_W/8-1:0]   i_be,
  input  logic [DATA_W-1:0]     i_wdata,
  output logic [DATA_W-1:0]     o_q
);

  logic [DATA_W-1:0] r_mem [2**ADDR_W];
  logic [DATA_W-1:0] r_q;

  // Byte-masked write; registered read returns the pre-write contents.
  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int unsigned b = 0; b < DATA_W/8; b++) begin
        if (i_be[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
    r_q <= r_mem[i_addr];
  end

  assign o_q = r_q;

endmodule

// File: rtl/cpu_jtag_ocimem.sv
// cpu_jtag_ocimem: sysclk-side OCI debug monitor memory shared by JTAG and the Avalon debug slave.
// Optional: define OCIMEM_ROM_PROTECT_EN to make words 0..63 read-only from both masters.
module cpu_jtag_ocimem #(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned DATA_W    = 32,
  parameter string       INIT_FILE = ""
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [37:0]           jdo,
  input  logic                  take_action_ocimem_a,
  input  logic                  take_action_ocimem_b,
  input  logic                  take_no_action_ocimem_a,
  input  logic [ADDR_W-1:0]     av_address,
  input  logic                  av_read,
  input  logic                  av_write,
  input  logic [DATA_W-1:0]     av_writedata,
  input  logic [DATA_W/8-1:0]   av_byteenable,
  input  logic                  av_debugaccess,
  output logic [DATA_W-1:0]     av_readdata,
  output logic                  av_waitrequest,
  output logic [DATA_W-1:0]     MonDReg,
  output logic                  monitor_ready,
  output logic                  monitor_error
);

  import cpu_ocimem_pkg::*;

  ocimem_state_e     r_state, w_next;
  logic [ADDR_W-1:0] r_mon_addr;
  logic [DATA_W-1:0] r_mon_dreg, r_readdata;
  logic              r_ready, r_error, r_ready_set, r_hold_addr;
  logic              r_pend_vld;
  jtag_cmd_e         r_pend_cmd;
  logic [JDO_W-1:0]  r_pend_jdo;

  jtag_cmd_e         w_live_cmd, w_cmd;
  logic [JDO_W-1:0]  w_cmd_jdo;
  logic [ADDR_W-1:0] w_j_addr;
  logic [DATA_W-1:0] w_j_wdata;
  logic              w_j_rdreq, w_j_errclr, w_pend_cap, w_idle_free;
  logic              w_av_wr, w_av_wr_ok, w_j_wr_ok;
  logic [ADDR_W-1:0] w_ram_addr;
  logic              w_ram_we;
  logic [DATA_W/8-1:0] w_ram_be;
  logic [DATA_W-1:0] w_ram_wdata, w_ram_q;
  logic              w_unused;

  // Decode the live strobe (at most one is high per cycle).
  always_comb begin
    w_live_cmd = JC_NONE;
    if (take_action_ocimem_a)         w_live_cmd = JC_LOAD;
    else if (take_no_action_ocimem_a) w_live_cmd = JC_READ;
    else if (take_action_ocimem_b)    w_live_cmd = JC_WRITE;
  end

  // A parked strobe runs first on return to IDLE; a live strobe arriving then is parked in its place.
  assign w_cmd      = (r_state != IDLE) ? JC_NONE : (r_pend_vld ? r_pend_cmd : w_live_cmd);
  assign w_cmd_jdo  = r_pend_vld ? r_pend_jdo : jdo;
  assign w_pend_cap = (w_live_cmd != JC_NONE) && ((r_state != IDLE) || r_pend_vld);

  assign w_j_addr   = w_cmd_jdo[JDO_ADDR_LSB +: ADDR_W];
  assign w_j_wdata  = w_cmd_jdo[JDO_WDATA_LSB +: DATA_W];
  assign w_j_rdreq  = w_cmd_jdo[JDO_RDREQ];
  assign w_j_errclr = w_cmd_jdo[JDO_ERRCLR];
  assign w_unused   = ^{w_cmd_jdo[JDO_W-1:JDO_ERRCLR+1], w_cmd_jdo[JDO_WDATA_LSB-1:0]};

  assign w_idle_free = (r_state == IDLE) && (w_cmd == JC_NONE);
  assign w_av_wr     = w_idle_free && !av_read && av_write;

`ifdef OCIMEM_ROM_PROTECT_EN
  assign w_av_wr_ok = av_debugaccess && !rom_protected(32'(av_address));
  assign w_j_wr_ok  = !rom_protected(32'(r_mon_addr));
`else
  assign w_av_wr_ok = av_debugaccess;
  assign w_j_wr_ok  = 1'b1;
`endif

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next-state selection; JTAG wins over Avalon in IDLE.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        case (w_cmd)
          JC_LOAD:  w_next = w_j_rdreq ? J_RD : IDLE;
          JC_READ:  w_next = J_RD;
          JC_WRITE: w_next = J_WR;
          default: begin
            if (av_read)       w_next = A_RD;
            else if (av_write) w_next = A_ACK;
          end
        endcase
      end
      J_RD, J_WR, A_ACK: w_next = IDLE;
      A_RD:              w_next = A_ACK;
      default:           w_next = IDLE;
    endcase
  end

  // RAM port steering and Avalon stall.
  always_comb begin
    w_ram_addr     = r_mon_addr;
    w_ram_we       = 1'b0;
    w_ram_be       = '1;
    w_ram_wdata    = w_j_wdata;
    av_waitrequest = 1'b1;
    if (r_state == IDLE) begin
      case (w_cmd)
        JC_LOAD:  w_ram_addr = w_j_addr;
        JC_WRITE: w_ram_we   = w_j_wr_ok;
        JC_READ:  w_ram_addr = r_mon_addr;
        default: begin
          w_ram_addr  = av_address;
          w_ram_be    = av_byteenable;
          w_ram_wdata = av_writedata;
          w_ram_we    = w_av_wr && w_av_wr_ok;
        end
      endcase
    end
    if (!reset && ((r_state == A_ACK) || w_av_wr)) av_waitrequest = 1'b0;
  end

  // Monitor registers, address counter and pending strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mon_addr  <= '0;
      r_mon_dreg  <= '0;
      r_readdata  <= '0;
      r_ready     <= 1'b0;
      r_error     <= 1'b0;
      r_ready_set <= 1'b0;
      r_hold_addr <= 1'b0;
      r_pend_vld  <= 1'b0;
      r_pend_cmd  <= JC_NONE;
      r_pend_jdo  <= '0;
    end else begin
      r_ready_set <= 1'b0;
      if (r_ready_set) r_ready <= 1'b1;
      if (w_pend_cap) begin
        r_pend_vld <= 1'b1;
        r_pend_cmd <= w_live_cmd;
        r_pend_jdo <= jdo;
      end else if (r_state == IDLE) begin
        r_pend_vld <= 1'b0;
      end
      case (r_state)
        IDLE: begin
          case (w_cmd)
            JC_LOAD: begin
              r_mon_addr <= w_j_addr;
              r_ready    <= 1'b0;
              if (w_j_errclr) r_error <= 1'b0;
              if (w_j_rdreq) r_hold_addr <= 1'b1;
              else           r_ready_set <= 1'b1;
            end
            JC_READ: begin
              r_ready     <= 1'b0;
              r_hold_addr <= 1'b0;
            end
            JC_WRITE: begin
              r_mon_dreg <= w_j_wdata;
              r_ready    <= 1'b0;
              if (!w_j_wr_ok) r_error <= 1'b1;
            end
            default: if (w_av_wr && !w_av_wr_ok) r_error <= 1'b1;
          endcase
        end
        J_RD: begin
          r_mon_dreg <= w_ram_q;
          if (!r_hold_addr) r_mon_addr <= r_mon_addr + 1'b1;
          r_ready <= 1'b1;
        end
        J_WR: begin
          r_mon_addr <= r_mon_addr + 1'b1;
          r_ready    <= 1'b1;
        end
        A_RD:    r_readdata <= w_ram_q;
        default: ;
      endcase
    end
  end

  assign MonDReg       = r_mon_dreg;
  assign monitor_ready = r_ready;
  assign monitor_error = r_error;
  assign av_readdata   = r_readdata;

  cpu_ocimem_ram #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .INIT_FILE (INIT_FILE)
  ) u_ram (
    .clk     (clk),
    .i_addr  (w_ram_addr),
    .i_we    (w_ram_we),
    .i_be    (w_ram_be),
    .i_wdata (w_ram_wdata),
    .o_q     (w_ram_q)
  );

endmodule

// File: tb/tb_cpu_jtag_ocimem.sv
// tb_cpu_jtag_ocimem: directed + randomized checks of cpu_jtag_ocimem against a transaction-level model.
module tb_cpu_jtag_ocimem;

  logic        clk = 1'b0;
  logic        reset;
  logic [37:0] jdo;
  logic        ta_a, ta_b, tna_a;
  logic [7:0]  av_address;
  logic        av_read, av_write, av_debugaccess;
  logic [31:0] av_writedata;
  logic [3:0]  av_byteenable;
  logic [31:0] av_readdata, MonDReg;
  logic        av_waitrequest, monitor_ready, monitor_error;

  always #5 clk = ~clk;

  cpu_jtag_ocimem dut (
    .clk                     (clk),
    .reset                   (reset),
    .jdo                     (jdo),
    .take_action_ocimem_a    (ta_a),
    .take_action_ocimem_b    (ta_b),
    .take_no_action_ocimem_a (tna_a),
    .av_address              (av_address),
    .av_read                 (av_read),
    .av_write                (av_write),
    .av_writedata            (av_writedata),
    .av_byteenable           (av_byteenable),
    .av_debugaccess          (av_debugaccess),
    .av_readdata             (av_readdata),
    .av_waitrequest          (av_waitrequest),
    .MonDReg                 (MonDReg),
    .monitor_ready           (monitor_ready),
    .monitor_error           (monitor_error)
  );

  int unsigned n_vec  = 0;
  int unsigned n_miss = 0;

  // Reference model: memory image plus the three JTAG-visible monitor values.
  logic [31:0] m_mem [256];
  int unsigned m_addr;
  logic        m_err;
  logic [31:0] m_dreg;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [37:0] rnd_jdo();
    return 38'({$urandom(), $urandom()});
  endfunction

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_dreg"}, MonDReg, 32'h0);
    chk({tag, "_ready"}, 32'(monitor_ready), 32'h0);
    chk({tag, "_err"}, 32'(monitor_error), 32'h0);
    chk({tag, "_rdata"}, av_readdata, 32'h0);
    chk({tag, "_wait"}, 32'(av_waitrequest), 32'h1);
  endtask

  task automatic model_reset();
    m_addr = 0;
    m_err  = 1'b0;
    m_dreg = '0;
  endtask

  task automatic j_load(input logic [7:0] a, input bit rd, input bit ec);
    logic [37:0] j;
    j = rnd_jdo();
    j[24:17] = a;
    j[34]    = rd;
    j[35]    = ec;
    jdo = j; ta_a = 1'b1;
    tick();
    ta_a = 1'b0; jdo = rnd_jdo();
    m_addr = a;
    if (ec) m_err = 1'b0;
    if (rd) m_dreg = m_mem[a];
    chk("load_busy", 32'(monitor_ready), 32'h0);
    tick();
    chk("load_ready", 32'(monitor_ready), 32'h1);
    chk("load_dreg", MonDReg, m_dreg);
    chk("load_err", 32'(monitor_error), 32'(m_err));
  endtask

  task automatic j_read();
    jdo = rnd_jdo(); tna_a = 1'b1;
    tick();
    tna_a = 1'b0;
    m_dreg = m_mem[m_addr];
    m_addr = (m_addr + 1) % 256;
    chk("jrd_busy", 32'(monitor_ready), 32'h0);
    tick();
    chk("jrd_ready", 32'(monitor_ready), 32'h1);
    chk("jrd_dreg", MonDReg, m_dreg);
  endtask

  task automatic j_write(input logic [31:0] d);
    logic [37:0] j;
    j = rnd_jdo();
    j[34:3] = d;
    jdo = j; ta_b = 1'b1;
    tick();
    ta_b = 1'b0; jdo = rnd_jdo();
    m_mem[m_addr] = d;
    m_dreg = d;
    m_addr = (m_addr + 1) % 256;
    chk("jwr_busy", 32'(monitor_ready), 32'h0);
    chk("jwr_dreg", MonDReg, m_dreg);
    tick();
    chk("jwr_ready", 32'(monitor_ready), 32'h1);
  endtask

  task automatic av_rd(input logic [7:0] a);
    int cyc;
    av_address = a; av_read = 1'b1;
    #1;
    cyc = 0;
    while (av_waitrequest !== 1'b0 && cyc < 10) begin
      tick();
      cyc++;
    end
    chk("avrd_lat", 32'(cyc), 32'd2);
    chk("avrd_data", av_readdata, m_mem[a]);
    tick();
    av_read = 1'b0; av_address = 8'($urandom());
  endtask

  task automatic av_wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be, input bit dbg);
    int cyc;
    av_address = a; av_writedata = d; av_byteenable = be; av_debugaccess = dbg; av_write = 1'b1;
    #1;
    cyc = 0;
    while (av_waitrequest !== 1'b0 && cyc < 10) begin
      tick();
      cyc++;
    end
    chk("avwr_lat", 32'(cyc), 32'd0);
    tick();
    av_write = 1'b0; av_writedata = $urandom();
    if (dbg) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) m_mem[a][8*b +: 8] = d[8*b +: 8];
    end else begin
      m_err = 1'b1;
    end
    chk("avwr_err", 32'(monitor_error), 32'(m_err));
    chk("avwr_ack", 32'(av_waitrequest), 32'h0);
    tick();
  endtask

  initial begin
    reset = 1'b1; jdo = '0; ta_a = 1'b0; ta_b = 1'b0; tna_a = 1'b0;
    av_address = '0; av_read = 1'b0; av_write = 1'b0; av_writedata = '0;
    av_byteenable = '0; av_debugaccess = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("rst");
    reset = 1'b0;
    tick();
    chk_reset_vals("post_rst");

    // Fill the whole memory through JTAG streaming writes (address wraps back to 0).
    j_load(8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 256; i++) j_write($urandom());

    // Load-and-read: address-load reads do not advance the address.
    j_load(8'h10, 1'b0, 1'b0);
    j_write(32'hDEADBEEF);
    j_load(8'h10, 1'b1, 1'b0);
    j_read();
    j_read();

    // Streaming write across the 0xFF -> 0x00 wrap.
    j_load(8'hFF, 1'b0, 1'b0);
    j_write(32'h11111111);
    j_write(32'h22222222);
    j_read();
    av_rd(8'hFF);
    av_rd(8'h00);

    // Avalon read latency.
    j_load(8'h05, 1'b0, 1'b0);
    j_write(32'hCAFEF00D);
    av_rd(8'h05);

    // Avalon write without debugaccess is dropped and flags an error; JTAG clears it.
    av_wr(8'h20, 32'hFFFFFFFF, 4'hF, 1'b0);
    av_rd(8'h20);
    j_load(8'h33, 1'b0, 1'b1);

    // Collision: JTAG read and Avalon write in the same IDLE cycle.
    av_address = 8'h44; av_writedata = 32'hA5A55A5A; av_byteenable = 4'hF;
    av_debugaccess = 1'b1; av_write = 1'b1; tna_a = 1'b1;
    #1;
    chk("col_stall0", 32'(av_waitrequest), 32'h1);
    tick();
    tna_a = 1'b0;
    m_dreg = m_mem[m_addr];
    m_addr = (m_addr + 1) % 256;
    chk("col_stall1", 32'(av_waitrequest), 32'h1);
    tick();
    chk("col_wr_go", 32'(av_waitrequest), 32'h0);
    chk("col_jready", 32'(monitor_ready), 32'h1);
    chk("col_jdreg", MonDReg, m_dreg);
    tick();
    av_write = 1'b0;
    m_mem[8'h44] = 32'hA5A55A5A;
    tick();
    av_rd(8'h44);

    // JTAG strobe during A_RD is parked and executed after A_ACK.
    av_address = 8'h07; av_read = 1'b1;
    tick();
    tna_a = 1'b1;
    tick();
    tna_a = 1'b0;
    chk("pend_ack", 32'(av_waitrequest), 32'h0);
    chk("pend_rdata", av_readdata, m_mem[8'h07]);
    tick();
    av_read = 1'b0;
    m_dreg = m_mem[m_addr];
    m_addr = (m_addr + 1) % 256;
    tick();
    chk("pend_busy", 32'(monitor_ready), 32'h0);
    tick();
    chk("pend_ready", 32'(monitor_ready), 32'h1);
    chk("pend_dreg", MonDReg, m_dreg);

    // Reset asserted during A_RD.
    av_address = 8'h09; av_read = 1'b1;
    tick();
    #2 reset = 1'b1;
    #1;
    chk_reset_vals("rst_ard");
    av_read = 1'b0;
    tick();
    reset = 1'b0;
    #1;
    chk("rst_ard_idle_wait", 32'(av_waitrequest), 32'h1);
    model_reset();

    // Reset while a parked strobe is waiting: the strobe is discarded.
    av_address = 8'h0A; av_read = 1'b1;
    tick();
    tna_a = 1'b1;
    tick();
    tna_a = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk_reset_vals("rst_pend");
    av_read = 1'b0;
    tick();
    reset = 1'b0;
    repeat (3) tick();
    chk("rst_pend_ready", 32'(monitor_ready), 32'h0);
    chk("rst_pend_dreg", MonDReg, 32'h0);
    model_reset();

    // Memory survives reset; address restarts at 0.
    j_read();
    av_rd(8'hFF);
    av_rd(8'h10);

    // Randomized mix of all transaction kinds.
    for (int i = 0; i < 200; i++) begin
      case ($urandom_range(0, 4))
        0: j_load(8'($urandom()), 1'($urandom()), ($urandom_range(0, 3) == 0));
        1: j_read();
        2: j_write($urandom());
        3: av_rd(8'($urandom()));
        default: av_wr(8'($urandom()), $urandom(), 4'($urandom()), ($urandom_range(0, 3) != 0));
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
